// File: rtl/bitap_stream_matcher_if.sv
`default_nettype none
// ============================================================================
// Module      : bitap_stream_matcher_if
// Description : Byte-wide command port bundle for the bitap stream matcher.
//               master = host side, slave = matcher side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bitap_stream_matcher_if;
  logic       ena;
  logic       cs_n;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       match;
  logic       enabled;

  modport master (
    output ena, cs_n, din,
    input  dout, dout_valid, match, enabled
  );

  modport slave (
    input  ena, cs_n, din,
    output dout, dout_valid, match, enabled
  );
endinterface
`default_nettype wire

// File: rtl/bitap_stream_matcher.sv
`default_nettype none
// ============================================================================
// Module      : bitap_stream_matcher
// Description : Shift-and (bitap) byte-stream pattern matcher behind a
//               byte-wide command port. Host programs a character table with
//               per-character position masks plus a result mask, then streams
//               bytes; a match pulse fires when a result position goes active.
//               Optional feature macro: BITAP_CASE_FOLD_EN (CONFIG bit0 folds
//               ASCII upper case to lower case before comparison).
// Revision    : 1.0 - initial release
// ============================================================================
module bitap_stream_matcher #(
  parameter int POSITIONS = 16,
  parameter int ENTRIES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bitap_stream_matcher_if.slave bus
);

  localparam int MB = POSITIONS / 8;

  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_ENABLE  = 8'h81;
  localparam logic [7:0] OP_STREAM  = 8'h82;
  localparam logic [7:0] OP_DISABLE = 8'h83;

  localparam logic [7:0] ADDR_STATUS   = 8'h00;
  localparam logic [7:0] ADDR_COUNT_LO = 8'h01;
  localparam logic [7:0] ADDR_COUNT_HI = 8'h02;
  localparam logic [7:0] ADDR_CONFIG   = 8'h03;
  localparam int         BASE_RESULT   = 'h20;
  localparam int         BASE_CHAR     = 'h40;
  localparam int         BASE_MASK     = 'h80;

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_W_ADDR = 3'd1,
    ST_W_DATA = 3'd2,
    ST_R_ADDR = 3'd3,
    ST_S_DATA = 3'd4
  } parse_state_t;

  parse_state_t         r_pstate;
  parse_state_t         w_pstate_next;
  logic                 w_do_write;
  logic                 w_do_read;
  logic                 w_do_stream;
  logic                 w_do_enable;
  logic                 w_do_disable;
  logic                 w_latch_addr;

  logic [7:0]           r_waddr;
  logic [POSITIONS-1:0] r_result_mask;
  logic [7:0]           r_char [ENTRIES];
  logic [POSITIONS-1:0] r_mask [ENTRIES];
  logic                 w_fold;

  logic [POSITIONS-1:0] r_state;
  logic [POSITIONS-1:0] w_cmask;
  logic [POSITIONS-1:0] w_state_next;
  logic                 w_hit;
  logic                 r_enabled;
  logic                 r_sticky;
  logic                 r_match;
  logic [15:0]          r_count;

  logic [7:0]           w_rdata;
  logic [7:0]           r_dout;
  logic                 r_dout_valid;

  // ASCII 'A'..'Z' map to 'a'..'z' when folding is active
  function automatic logic [7:0] fold_byte(input logic [7:0] c, input logic en);
    if (en && (c >= 8'h41) && (c <= 8'h5A)) return c + 8'h20;
    return c;
  endfunction

`ifdef BITAP_CASE_FOLD_EN
  logic r_fold;
  assign w_fold = r_fold;
`else
  assign w_fold = 1'b0;
`endif

  // Parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pstate <= ST_CMD;
    else        r_pstate <= w_pstate_next;
  end

  // Parser next state and per-byte action strobes; cs_n high aborts at once
  always_comb begin
    w_pstate_next = r_pstate;
    w_do_write    = 1'b0;
    w_do_read     = 1'b0;
    w_do_stream   = 1'b0;
    w_do_enable   = 1'b0;
    w_do_disable  = 1'b0;
    w_latch_addr  = 1'b0;
    if (bus.cs_n) begin
      w_pstate_next = ST_CMD;
    end else if (bus.ena) begin
      case (r_pstate)
        ST_CMD: begin
          case (bus.din)
            OP_WRITE:   w_pstate_next = ST_W_ADDR;
            OP_READ:    w_pstate_next = ST_R_ADDR;
            OP_STREAM:  w_pstate_next = ST_S_DATA;
            OP_ENABLE:  w_do_enable   = 1'b1;
            OP_DISABLE: w_do_disable  = 1'b1;
            default:    w_pstate_next = ST_CMD;
          endcase
        end
        ST_W_ADDR: begin
          w_latch_addr  = 1'b1;
          w_pstate_next = ST_W_DATA;
        end
        ST_W_DATA: begin
          w_do_write    = 1'b1;
          w_pstate_next = ST_CMD;
        end
        ST_R_ADDR: begin
          w_do_read     = 1'b1;
          w_pstate_next = ST_CMD;
        end
        ST_S_DATA: begin
          w_do_stream   = 1'b1;
          w_pstate_next = ST_CMD;
        end
        default: w_pstate_next = ST_CMD;
      endcase
    end
  end

  // Capture the write address for the following data byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_waddr <= 8'h00;
    else if (w_latch_addr) r_waddr <= bus.din;
  end

  // Configuration registers: result mask, character table, position masks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result_mask <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_char[i] <= 8'h00;
        r_mask[i] <= '0;
      end
`ifdef BITAP_CASE_FOLD_EN
      r_fold <= 1'b0;
`endif
    end else if (w_do_write) begin
      for (int b = 0; b < MB; b++) begin
        if (r_waddr == 8'(BASE_RESULT + b)) r_result_mask[b*8 +: 8] <= bus.din;
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (r_waddr == 8'(BASE_CHAR + i)) r_char[i] <= bus.din;
        for (int b = 0; b < MB; b++) begin
          if (r_waddr == 8'(BASE_MASK + i*MB + b)) r_mask[i][b*8 +: 8] <= bus.din;
        end
      end
`ifdef BITAP_CASE_FOLD_EN
      if (r_waddr == ADDR_CONFIG) r_fold <= bus.din[0];
`endif
    end
  end

  // Character mask lookup and shift-and step for the current stream byte
  always_comb begin
    w_cmask = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (fold_byte(r_char[i], w_fold) == fold_byte(bus.din, w_fold)) w_cmask = w_cmask | r_mask[i];
    end
    w_state_next = {r_state[POSITIONS-2:0], 1'b1} & w_cmask;
    w_hit        = |(w_state_next & r_result_mask);
  end

  // Matcher state, enable, sticky flag, saturating match counter, match pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_enabled <= 1'b0;
      r_sticky  <= 1'b0;
      r_count   <= 16'h0000;
      r_match   <= 1'b0;
    end else begin
      r_match <= 1'b0;
      if (w_do_enable) begin
        r_enabled <= 1'b1;
        r_state   <= '0;
        r_sticky  <= 1'b0;
        r_count   <= 16'h0000;
      end else if (w_do_disable) begin
        r_enabled <= 1'b0;
      end else if (w_do_stream && r_enabled) begin
        r_state <= w_state_next;
        if (w_hit) begin
          r_match  <= 1'b1;
          r_sticky <= 1'b1;
          if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        end
      end
    end
  end

  // Register readback mux, addressed by the byte currently on din
  always_comb begin
    w_rdata = 8'h00;
    if (bus.din == ADDR_STATUS)   w_rdata = {6'b0, r_sticky, r_enabled};
    if (bus.din == ADDR_COUNT_LO) w_rdata = r_count[7:0];
    if (bus.din == ADDR_COUNT_HI) w_rdata = r_count[15:8];
`ifdef BITAP_CASE_FOLD_EN
    if (bus.din == ADDR_CONFIG)   w_rdata = {7'b0, r_fold};
`endif
    for (int b = 0; b < MB; b++) begin
      if (bus.din == 8'(BASE_RESULT + b)) w_rdata = r_result_mask[b*8 +: 8];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (bus.din == 8'(BASE_CHAR + i)) w_rdata = r_char[i];
      for (int b = 0; b < MB; b++) begin
        if (bus.din == 8'(BASE_MASK + i*MB + b)) w_rdata = r_mask[i][b*8 +: 8];
      end
    end
  end

  // Read data register: loads on the address byte, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= 8'h00;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_do_read;
      if (w_do_read) r_dout <= w_rdata;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.match      = r_match;
  assign bus.enabled    = r_enabled;

endmodule
`default_nettype wire

// File: tb/tb_bitap_stream_matcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_bitap_stream_matcher
// Description : Self-checking bench for bitap_stream_matcher: directed
//               scenarios followed by randomized traffic against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitap_stream_matcher;

  localparam int POSITIONS = 16;
  localparam int ENTRIES   = 8;
  localparam int MB        = POSITIONS / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  // reference model of the programmable matcher
  logic [7:0]           m_char [ENTRIES];
  logic [POSITIONS-1:0] m_mask [ENTRIES];
  logic [POSITIONS-1:0] m_rm;
  logic [POSITIONS-1:0] m_state;
  logic                 m_en;
  logic                 m_sticky;
  logic                 m_fold;
  logic [15:0]          m_count;

  bitap_stream_matcher_if bus_if ();

  bitap_stream_matcher #(
    .POSITIONS (POSITIONS),
    .ENTRIES   (ENTRIES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_char[i] = 8'h00;
      m_mask[i] = '0;
    end
    m_rm = '0; m_state = '0; m_en = 1'b0; m_sticky = 1'b0; m_fold = 1'b0; m_count = 16'h0000;
  endtask

  function automatic logic [7:0] fold(input logic [7:0] c);
    if (m_fold && c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
    return c;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    int ai;
    ai = int'(a);
    if (ai >= 'h20 && ai < 'h20 + MB) m_rm[(ai - 'h20)*8 +: 8] = d;
    else if (ai >= 'h40 && ai < 'h40 + ENTRIES) m_char[ai - 'h40] = d;
    else if (ai >= 'h80 && ai < 'h80 + ENTRIES*MB) m_mask[(ai - 'h80)/MB][((ai - 'h80)%MB)*8 +: 8] = d;
`ifdef BITAP_CASE_FOLD_EN
    else if (ai == 3) m_fold = d[0];
`endif
  endtask

  function automatic logic [7:0] exp_reg(input logic [7:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return {6'b0, m_sticky, m_en};
    if (ai == 1) return m_count[7:0];
    if (ai == 2) return m_count[15:8];
`ifdef BITAP_CASE_FOLD_EN
    if (ai == 3) return {7'b0, m_fold};
`endif
    if (ai >= 'h20 && ai < 'h20 + MB) return m_rm[(ai - 'h20)*8 +: 8];
    if (ai >= 'h40 && ai < 'h40 + ENTRIES) return m_char[ai - 'h40];
    if (ai >= 'h80 && ai < 'h80 + ENTRIES*MB) return m_mask[(ai - 'h80)/MB][((ai - 'h80)%MB)*8 +: 8];
    return 8'h00;
  endfunction

  // Pattern state as a number: shift = multiply by 2, new start = +1,
  // keep only positions the character allows.
  task automatic model_stream(input logic [7:0] c, output logic hit);
    logic [POSITIONS-1:0] cm;
    logic [63:0]          wide;
    hit = 1'b0;
    if (!m_en) return;
    cm = '0;
    for (int i = 0; i < ENTRIES; i++) if (fold(m_char[i]) == fold(c)) cm = cm | m_mask[i];
    wide    = (64'(m_state) * 64'd2 + 64'd1) & 64'(cm);
    m_state = wide[POSITIONS-1:0];
    hit     = (m_state & m_rm) != '0;
    if (hit) begin
      m_sticky = 1'b1;
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus_if.ena = 1'b1; bus_if.cs_n = 1'b0; bus_if.din = b;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus_if.ena = 1'b0; bus_if.cs_n = 1'b1; bus_if.din = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic stall(input logic [7:0] b);
    @(negedge clk);
    bus_if.ena = 1'b0; bus_if.cs_n = 1'b0; bus_if.din = b;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    put(8'h02); put(a); put(d);
    model_write(a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a);
    put(8'h03); put(a);
    chk({tag, "_vld"}, 8'(bus_if.dout_valid), 8'h01);
    chk(tag, bus_if.dout, exp_reg(a));
  endtask

  task automatic en_cmd();
    put(8'h81);
    m_en = 1'b1; m_state = '0; m_sticky = 1'b0; m_count = 16'h0000;
  endtask

  task automatic dis_cmd();
    put(8'h83);
    m_en = 1'b0;
  endtask

  // exp_m < 0 means take the expectation from the model
  task automatic strm(input logic [7:0] c, input int exp_m);
    logic hit;
    put(8'h82);
    chk("match_gap", 8'(bus_if.match), 8'h00);
    put(c);
    model_stream(c, hit);
    if (exp_m >= 0) chk("match_dir", 8'(bus_if.match), 8'(exp_m));
    else            chk("match_rnd", 8'(bus_if.match), 8'(hit));
  endtask

  task automatic prog_abc();
    wr(8'h20, 8'h04); wr(8'h21, 8'h00);
    wr(8'h40, 8'h61); wr(8'h41, 8'h62); wr(8'h42, 8'h63);
    wr(8'h80, 8'h01); wr(8'h81, 8'h00);
    wr(8'h82, 8'h02); wr(8'h83, 8'h00);
    wr(8'h84, 8'h04); wr(8'h85, 8'h00);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    int         r;

    bus_if.ena = 1'b0; bus_if.cs_n = 1'b1; bus_if.din = 8'h00;
    model_reset();

    // reset state
    #12;
    chk("rst_dout",    bus_if.dout, 8'h00);
    chk("rst_dvalid",  8'(bus_if.dout_valid), 8'h00);
    chk("rst_match",   8'(bus_if.match), 8'h00);
    chk("rst_enabled", 8'(bus_if.enabled), 8'h00);
    @(negedge clk); rst_n = 1'b1;
    idle();

    // readback, dout hold, unmapped read
    wr(8'h40, 8'h5A);
    rd_chk("rd_char0", 8'h40);
    idle();
    chk("dvalid_one_cycle", 8'(bus_if.dout_valid), 8'h00);
    chk("dout_hold", bus_if.dout, 8'h5A);
    rd_chk("rd_unmapped_3f", 8'h3F);
    chk("rd_unmapped_val", bus_if.dout, 8'h00);

    // ena=0 cycles hold the parser
    put(8'h03); stall(8'h00); put(8'h40);
    chk("stall_vld", 8'(bus_if.dout_valid), 8'h01);
    chk("stall_dout", bus_if.dout, 8'h5A);

    // cs_n abort of a partial write
    put(8'h02); put(8'h40);
    @(negedge clk); bus_if.ena = 1'b1; bus_if.cs_n = 1'b1; bus_if.din = 8'h77;
    @(posedge clk); #1;
    put(8'h55);
    rd_chk("abort_char0", 8'h40);

    // writes to read-only registers are ignored
    wr(8'h00, 8'hFF); wr(8'h01, 8'hFF);
    rd_chk("ro_status", 8'h00);
    rd_chk("ro_count", 8'h01);

    // simple abc pattern
    prog_abc();
    en_cmd();
    chk("enabled_out", 8'(bus_if.enabled), 8'h01);
    strm(8'h61, 0); strm(8'h62, 0); strm(8'h63, 1); strm(8'h64, 0); strm(8'h00, 0);
    rd_chk("t1_cnt_lo", 8'h01);
    chk("t1_cnt_lo_val", bus_if.dout, 8'h01);
    rd_chk("t1_cnt_hi", 8'h02);
    rd_chk("t1_status", 8'h00);
    chk("t1_status_val", bus_if.dout, 8'h03);

    // overlapping matches
    wr(8'h80, 8'h03); wr(8'h81, 8'h00);
    wr(8'h20, 8'h02); wr(8'h21, 8'h00);
    en_cmd();
    strm(8'h61, 0); strm(8'h61, 1); strm(8'h61, 1);
    rd_chk("t2_cnt_lo", 8'h01);
    chk("t2_cnt_val", bus_if.dout, 8'h02);

    // disabled stream: no match, counter held, sticky kept
    dis_cmd();
    chk("disabled_out", 8'(bus_if.enabled), 8'h00);
    strm(8'h61, 0); strm(8'h62, 0); strm(8'h63, 0);
    rd_chk("t5_cnt_lo", 8'h01);
    chk("t5_cnt_val", bus_if.dout, 8'h02);
    rd_chk("t5_status", 8'h00);
    chk("t5_status_val", bus_if.dout, 8'h02);

    // ENABLE while enabled clears counter and sticky
    en_cmd(); strm(8'h61, 0); strm(8'h61, 1);
    en_cmd();
    rd_chk("reen_cnt", 8'h01);
    rd_chk("reen_status", 8'h00);
    chk("reen_status_val", bus_if.dout, 8'h01);

    // case folding
    prog_abc();
    en_cmd();
    strm(8'h41, 0); strm(8'h42, 0); strm(8'h43, 0);
    wr(8'h03, 8'h01);
    rd_chk("config_rd", 8'h03);
`ifdef BITAP_CASE_FOLD_EN
    chk("config_val", bus_if.dout, 8'h01);
    strm(8'h41, 0); strm(8'h42, 0); strm(8'h43, 1);
    wr(8'h40, 8'h41);
    rd_chk("fold_char_raw", 8'h40);
    chk("fold_char_val", bus_if.dout, 8'h41);
    strm(8'h61, 0); strm(8'h62, 0); strm(8'h63, 1);
`else
    chk("config_val", bus_if.dout, 8'h00);
    strm(8'h41, 0); strm(8'h42, 0); strm(8'h43, 0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < ENTRIES; i++) begin
      wr(8'(8'h40 + i), 8'(8'h61 + $urandom_range(0, 3)));
      for (int b = 0; b < MB; b++) wr(8'(8'h80 + i*MB + b), 8'($urandom_range(0, 255)));
    end
    for (int b = 0; b < MB; b++) wr(8'(8'h20 + b), 8'($urandom_range(1, 255)));
    en_cmd();
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 11));
      if (r < 8) begin
        d = 8'($urandom_range(0, 4));
        strm(($urandom_range(0, 3) == 0) ? d + 8'h41 : d + 8'h61, -1);
      end else if (r == 8) begin
        stall(8'($urandom_range(0, 255)));
      end else if (r == 9) begin
        idle();
      end else if (r == 10) begin
        a = 8'(8'h80 + $urandom_range(0, ENTRIES*MB - 1));
        wr(a, 8'($urandom_range(0, 255)));
      end else begin
        rd_chk("rnd_rd", 8'($urandom_range(0, 255)));
      end
    end
    rd_chk("rnd_cnt_lo", 8'h01);
    rd_chk("rnd_cnt_hi", 8'h02);
    rd_chk("rnd_status", 8'h00);

    // asynchronous reset in the middle of a stream command
    put(8'h82);
    @(negedge clk); bus_if.ena = 1'b1; bus_if.cs_n = 1'b0; bus_if.din = 8'h61;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout",    bus_if.dout, 8'h00);
    chk("arst_dvalid",  8'(bus_if.dout_valid), 8'h00);
    chk("arst_match",   8'(bus_if.match), 8'h00);
    chk("arst_enabled", 8'(bus_if.enabled), 8'h00);
    model_reset();
    bus_if.ena = 1'b0; bus_if.cs_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    idle();
    for (int ai = 0; ai < 256; ai++) begin
      rd_chk("post_rst_reg", 8'(ai));
      chk("post_rst_zero", bus_if.dout, 8'h00);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
